// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: control-side mode/target inputs and the fetch address outputs.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [1:0]       pc_src;
    logic [WIDTH-1:0] immediate_32;
    logic [WIDTH-7:0] jump_index;
    logic [WIDTH-1:0] reg_target;
    logic             link;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             misaligned;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output stall, pc_src, immediate_32, jump_index, reg_target, link,
        input  pc, pc_plus4, misaligned, ras_empty, ras_full
    );

    modport slave (
        input  stall, pc_src, immediate_32, jump_index, reg_target, link,
        output pc, pc_plus4, misaligned, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump/register next-PC selection with stall.
// Optional return-address stack is built when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_REG    = 2'd3
    } pc_src_e;

    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

    logic [WIDTH-1:0] pc_q;
    logic             misaligned_q;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target_raw;
    logic             misaligned_next;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;

    assign pc_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        target_raw = pc_plus4;
        case (pc_src_e'(bus.pc_src))
            SRC_SEQ:    target_raw = pc_plus4;
            SRC_BRANCH: target_raw = pc_plus4 + (bus.immediate_32 << 2);
            SRC_JUMP:   target_raw = {pc_plus4[WIDTH-1 -: 4], bus.jump_index, 2'b00};
            SRC_REG:    target_raw = ras_pop ? ras_top : bus.reg_target;
            default:    target_raw = pc_plus4;
        endcase
    end

    // Only a register-supplied target can be unaligned; it is reported, then truncated.
    assign misaligned_next = (bus.pc_src == SRC_REG) && (target_raw[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q         <= word_align(target_raw);
            misaligned_q <= misaligned_next;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q;
    logic [CNT_W-1:0] ras_cnt_q;
    logic             ras_push;

    // ras_ptr_q is the next write slot; the top entry sits one below it.
    assign ras_push = bus.link;
    assign ras_pop  = (bus.pc_src == SRC_REG) && (ras_cnt_q != '0);
    assign ras_top  = ras_mem[ras_ptr_q - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (!bus.stall) begin
            if (ras_push && ras_pop) begin
                ras_mem[ras_ptr_q - PTR_W'(1)] <= pc_plus4;
            end else if (ras_push) begin
                // When full this overwrites the oldest entry and the count saturates.
                ras_mem[ras_ptr_q] <= pc_plus4;
                ras_ptr_q          <= ras_ptr_q + PTR_W'(1);
                if (ras_cnt_q != CNT_W'(RAS_DEPTH))
                    ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end else if (ras_pop) begin
                ras_ptr_q <= ras_ptr_q - PTR_W'(1);
                ras_cnt_q <= ras_cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.ras_empty = (ras_cnt_q == '0);
    assign bus.ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
`else
    logic unused_cfg;

    assign ras_pop       = 1'b0;
    assign ras_top       = '0;
    assign unused_cfg    = ^{bus.link, 32'(RAS_DEPTH)};
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
`endif

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; RAS scenarios run when PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_sequencer_if #(.WIDTH(32)) bus ();

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [25:0] ji,
                         input logic [31:0] rt, input logic lnk, input logic stl);
        bus.pc_src       = src;
        bus.immediate_32 = imm;
        bus.jump_index   = ji;
        bus.reg_target   = rt;
        bus.link         = lnk;
        bus.stall        = stl;
    endtask

    // Load an absolute PC through mode 3; only used while the RAS is empty.
    task automatic goto_pc(input logic [31:0] addr);
        drive(2'd3, 32'h0, 26'h0, addr, 1'b0, 1'b0);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'd2, 32'h5, 26'h3, 32'h7, 1'b1, 1'b1);
        cycle();
        n_cmp++; if (bus.pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc_plus4 got %h want %h", bus.pc_plus4, 32'h4); end
        n_cmp++; if (bus.misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_misaligned got %b want 0", bus.misaligned); end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ras_empty got %b want 1", bus.ras_empty); end
        n_cmp++; if (bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_ras_full got %b want 0", bus.ras_full); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        drive(2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            n_cmp++; if (bus.pc !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc%0d got %h want %h", i, bus.pc, 32'(4 * i)); end
        end
        n_cmp++; if (bus.pc_plus4 !== 32'h10) begin n_bad++; $display("FAIL seq_pc_plus4 got %h want %h", bus.pc_plus4, 32'h10); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++; if (bus.pc !== 32'h0) begin n_bad++; $display("FAIL seq_rerst_pc got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL seq_rerst_empty got %b want 1", bus.ras_empty); end
    endtask

    task automatic test_branch();
        do_reset();
        goto_pc(32'h100);
        n_cmp++; if (bus.pc !== 32'h100) begin n_bad++; $display("FAIL goto_pc got %h want %h", bus.pc, 32'h100); end
        drive(2'd1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'hFC) begin n_bad++; $display("FAIL branch_back got %h want %h", bus.pc, 32'hFC); end
        goto_pc(32'h100);
        drive(2'd1, 32'h3, 26'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h110) begin n_bad++; $display("FAIL branch_fwd got %h want %h", bus.pc, 32'h110); end
        goto_pc(32'h100);
        drive(2'd1, 32'h3, 26'h0, 32'h0, 1'b0, 1'b1);
        cycle();
        n_cmp++; if (bus.pc !== 32'h100) begin n_bad++; $display("FAIL branch_stall got %h want %h", bus.pc, 32'h100); end
        drive(2'd2, 32'h0, 26'h3F_FFFF, 32'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h00FF_FFFC) begin n_bad++; $display("FAIL jump_plain got %h want %h", bus.pc, 32'h00FF_FFFC); end
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(2'd3, 32'h0, 26'h0, 32'h203, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h200) begin n_bad++; $display("FAIL misal_pc got %h want %h", bus.pc, 32'h200); end
        n_cmp++; if (bus.misaligned !== 1'b1) begin n_bad++; $display("FAIL misal_set got %b want 1", bus.misaligned); end
        drive(2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        cycle();
        n_cmp++; if (bus.misaligned !== 1'b1) begin n_bad++; $display("FAIL misal_stall got %b want 1", bus.misaligned); end
        n_cmp++; if (bus.pc !== 32'h200) begin n_bad++; $display("FAIL misal_stall_pc got %h want %h", bus.pc, 32'h200); end
        drive(2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.misaligned !== 1'b0) begin n_bad++; $display("FAIL misal_clear got %b want 0", bus.misaligned); end
        n_cmp++; if (bus.pc !== 32'h204) begin n_bad++; $display("FAIL misal_next_pc got %h want %h", bus.pc, 32'h204); end
    endtask

`ifdef PC_SEQUENCER_RAS_EN
    task automatic test_jump_link_return();
        do_reset();
        drive(2'd2, 32'h0, 26'h40, 32'h0, 1'b1, 1'b1);
        cycle();
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL stall_link_empty got %b want 1", bus.ras_empty); end
        goto_pc(32'h4000_0010);
        drive(2'd2, 32'h0, 26'h40, 32'h0, 1'b1, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h4000_0100) begin n_bad++; $display("FAIL jal_pc got %h want %h", bus.pc, 32'h4000_0100); end
        n_cmp++; if (bus.ras_empty !== 1'b0) begin n_bad++; $display("FAIL jal_empty got %b want 0", bus.ras_empty); end
        drive(2'd3, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h4000_0014) begin n_bad++; $display("FAIL ret_pc got %h want %h", bus.pc, 32'h4000_0014); end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL ret_empty got %b want 1", bus.ras_empty); end
    endtask

    task automatic test_push_pop_same_cycle();
        do_reset();
        goto_pc(32'h1000);
        drive(2'd2, 32'h0, 26'h800, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(2'd3, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h1004) begin n_bad++; $display("FAIL pp_pc got %h want %h", bus.pc, 32'h1004); end
        n_cmp++; if (bus.ras_empty !== 1'b0) begin n_bad++; $display("FAIL pp_empty got %b want 0", bus.ras_empty); end
        drive(2'd3, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h2004) begin n_bad++; $display("FAIL pp_ret_pc got %h want %h", bus.pc, 32'h2004); end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL pp_ret_empty got %b want 1", bus.ras_empty); end
    endtask

    task automatic test_ras_overflow();
        do_reset();
        goto_pc(32'h1000);
        // Call k is made from k*0x1000, so its return address is k*0x1000+4.
        for (int k = 1; k <= 5; k++) begin
            drive(2'd2, 32'h0, 26'((k + 1) * 32'h400), 32'h0, 1'b1, 1'b0);
            cycle();
            n_cmp++; if (bus.pc !== 32'((k + 1) * 32'h1000)) begin n_bad++; $display("FAIL call%0d_pc got %h want %h", k, bus.pc, 32'((k + 1) * 32'h1000)); end
            n_cmp++; if (bus.ras_full !== (k >= 4)) begin n_bad++; $display("FAIL call%0d_full got %b want %b", k, bus.ras_full, (k >= 4)); end
        end
        for (int k = 5; k >= 2; k--) begin
            drive(2'd3, 32'h0, 26'h0, 32'h200, 1'b0, 1'b0);
            cycle();
            n_cmp++; if (bus.pc !== 32'(k * 32'h1000 + 4)) begin n_bad++; $display("FAIL ret_a%0d got %h want %h", k, bus.pc, 32'(k * 32'h1000 + 4)); end
        end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_empty got %b want 1", bus.ras_empty); end
        n_cmp++; if (bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL ovf_full got %b want 0", bus.ras_full); end
        cycle();
        n_cmp++; if (bus.pc !== 32'h200) begin n_bad++; $display("FAIL ret_reg got %h want %h", bus.pc, 32'h200); end
        for (int k = 0; k < 4; k++) begin
            drive(2'd2, 32'h0, 26'h100, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        n_cmp++; if (bus.ras_full !== 1'b1) begin n_bad++; $display("FAIL refill_full got %b want 1", bus.ras_full); end
        rst = 1'b1;
        drive(2'd3, 32'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        cycle();
        rst = 1'b0;
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL midcall_rst_empty got %b want 1", bus.ras_empty); end
        n_cmp++; if (bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL midcall_rst_full got %b want 0", bus.ras_full); end
        drive(2'd3, 32'h0, 26'h0, 32'h300, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h300) begin n_bad++; $display("FAIL midcall_rst_ret got %h want %h", bus.pc, 32'h300); end
    endtask
`else
    task automatic test_ras_disabled();
        do_reset();
        drive(2'd2, 32'h0, 26'h40, 32'h0, 1'b1, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h100) begin n_bad++; $display("FAIL nras_jal_pc got %h want %h", bus.pc, 32'h100); end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL nras_jal_empty got %b want 1", bus.ras_empty); end
        drive(2'd3, 32'h0, 26'h0, 32'h80, 1'b0, 1'b0);
        cycle();
        n_cmp++; if (bus.pc !== 32'h80) begin n_bad++; $display("FAIL nras_ret_pc got %h want %h", bus.pc, 32'h80); end
        n_cmp++; if (bus.ras_empty !== 1'b1) begin n_bad++; $display("FAIL nras_ret_empty got %b want 1", bus.ras_empty); end
        n_cmp++; if (bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL nras_full got %b want 0", bus.ras_full); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_sequential();
        test_branch();
        test_misaligned();
`ifdef PC_SEQUENCER_RAS_EN
        test_jump_link_return();
        test_push_pop_same_cycle();
        test_ras_overflow();
`else
        test_ras_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the SimpleCPU fetch stage. It owns the PC register and computes the next fetch address from four modes: sequential, PC-relative branch, absolute jump, and register/return jump. It supports fetch stall and an optional hardware return-address stack (RAS). The block sits between the control unit / branch comparator and the instruction memory address port.

## Interface

Parameters:
- `WIDTH`, 32: PC and data width. Must be at least 8.
- `RESET_PC`, 0: PC value loaded on reset. Must be word aligned.
- `RAS_DEPTH`, 4: number of RAS entries. Must be a power of two, at least 2. Ignored when RAS is compiled out.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the PC and RAS this cycle.
- `pc_src`  in  2  next-PC mode: 0 sequential, 1 branch, 2 jump, 3 register/return.
- `immediate_32`  in  WIDTH  sign-extended branch offset, in words.
- `jump_index`  in  WIDTH-6  absolute jump word index (26 bits at WIDTH=32).
- `reg_target`  in  WIDTH  register-supplied target for mode 3.
- `link`  in  1  call marker: push the return address this cycle.
- `pc`  out  WIDTH  current fetch address (registered).
- `pc_plus4`  out  WIDTH  `pc + 4`, combinational.
- `misaligned`  out  1  registered; set when a mode-3 target had bits [1:0] not equal to 0.
- `ras_empty`  out  1  RAS holds no entries.
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries.

## Operation

- Target by mode. All arithmetic is modulo 2^WIDTH and carries are discarded.
  - Mode 0: `pc_plus4`.
  - Mode 1: `pc_plus4 + (immediate_32 << 2)`.
  - Mode 2: `{pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00}`.
  - Mode 3: the popped RAS top if the RAS is enabled and not empty, otherwise `reg_target`. Bits [1:0] of the target are forced to 0 before loading into `pc`.
- `misaligned` is set on a non-stalled mode-3 cycle whose unmasked target had bits [1:0] not equal to 0. It is cleared on the next non-stalled update.
- RAS behaviour (when enabled):
  - `link=1`: push `pc_plus4` (the return address). This is valid in any mode and is typically paired with mode 2.
  - Mode 3 with RAS not empty: pop. Mode 3 with RAS empty: no pop, use `reg_target`.
  - Push and pop in the same cycle: the top entry is replaced by the new `pc_plus4` and the count is unchanged.
  - Push when full: the oldest entry is overwritten (circular wrap) and the count stays at `RAS_DEPTH`. No error is raised.
  - Implementation: circular buffer with a top pointer of log2(`RAS_DEPTH`) bits and a saturating count.
- `stall=1`: `pc`, `misaligned` and the RAS all hold. `pc_src` and `link` are ignored for that cycle.
- `rst=1` overrides stall and all other inputs.

## Timing

- Reset values, applied on the first rising edge with `rst=1`:
  - `pc` = `RESET_PC`
  - `misaligned` = 0
  - RAS count = 0, so `ras_empty` = 1 and `ras_full` = 0
  - RAS pointer = 0
- Latency: inputs sampled at edge N produce the new `pc` visible after edge N. This is one cycle, with no bubbles.
- `pc_plus4` follows `pc` combinationally in the same cycle.
- `ras_empty` and `ras_full` are decoded from the registered count and update after the edge that changes it.
- Reset asserted mid-stall or mid-call sequence discards all RAS contents. No partial state survives.

## Configuration

- Macro `PC_SEQUENCER_RAS_EN`.
- Defined: the RAS is built as described above.
- Undefined:
  - No RAS storage is built.
  - `link` is ignored.
  - Mode 3 always uses `reg_target`.
  - `ras_empty` is tied to 1 and `ras_full` is tied to 0.

## Test plan

All scenarios use WIDTH=32, RESET_PC=0, RAS_DEPTH=4, with the macro defined unless noted.

1. **Reset and sequential.** Reset, then 3 cycles of mode 0 -> `pc` reads 0, 4, 8, 12. Assert `rst` at `pc`=12 -> `pc`=0 on the next cycle and `ras_empty`=1.
2. **Branch.** At `pc`=0x100, mode 1 with `immediate_32`=0xFFFFFFFE -> `pc`=0xFC. At `pc`=0x100, offset 3 -> `pc`=0x110. Mode 1 with `stall`=1 -> `pc` holds at 0x100.
3. **Jump and link, then return.** At `pc`=0x40000010, mode 2 with `jump_index`=0x40 and `link`=1 -> `pc`=0x40000100 and `ras_empty`=0. Then mode 3 with `reg_target`=0 -> `pc`=0x40000014 and `ras_empty`=1.
4. **RAS overflow.** Perform 5 calls from `pc` values whose return addresses are A1..A5 -> `ras_full`=1. Then 4 returns -> targets A5, A4, A3, A2. A 5th return uses `reg_target`=0x200 -> `pc`=0x200.
5. **Misaligned register target.** Mode 3 with RAS empty and `reg_target`=0x203 -> `pc`=0x200 and `misaligned`=1. The next mode-0 cycle -> `misaligned`=0.
6. **RAS compiled out.** With the macro undefined, mode 2 with `link`=1 then mode 3 with `reg_target`=0x80 -> `pc`=0x80, and `ras_empty` stays 1 throughout.
